// File: rtl/hist_acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hist_acq_sequencer
// Brief    : Runs configure/clear/acquire/readout cycles on a histogram core
//            and re-emits the readout as an indexed bin stream.
// Revision : 1.0
// ============================================================================
module hist_acq_sequencer #(
  parameter int CHANNEL_WIDTH = 6,
  parameter int SHIFT_WIDTH   = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int BIN_COUNT     = 4096,
  parameter int CLEAR_CYCLES  = 4096,
  parameter int ACQ_WIDTH     = 32,
  parameter int READ_TIMEOUT  = 65536
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [CHANNEL_WIDTH-1:0]     cfg_click_channel_i,
  input  logic [CHANNEL_WIDTH-1:0]     cfg_start_channel_i,
  input  logic [SHIFT_WIDTH-1:0]       cfg_shift_val_i,
  input  logic [ACQ_WIDTH-1:0]         cfg_acq_cycles_i,
  input  logic [15:0]                  cfg_num_runs_i,
  output logic                         hist_config_en_o,
  output logic [CHANNEL_WIDTH-1:0]     hist_click_channel_o,
  output logic [CHANNEL_WIDTH-1:0]     hist_start_channel_o,
  output logic [SHIFT_WIDTH-1:0]       hist_shift_val_o,
  output logic                         hist_reset_o,
  output logic                         hist_read_start_o,
  input  logic [DATA_WIDTH-1:0]        hist_data_i,
  input  logic                         hist_valid_i,
  output logic [DATA_WIDTH-1:0]        m_data_o,
  output logic [$clog2(BIN_COUNT)-1:0] m_bin_o,
  output logic                         m_last_o,
  output logic                         m_valid_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [15:0]                  run_count_o,
  output logic                         error_o
);

  localparam int c_bin_w  = $clog2(BIN_COUNT);
  localparam int c_clr_w  = $clog2(CLEAR_CYCLES + 1);
  localparam int c_tmo_w  = $clog2(READ_TIMEOUT + 1);
  localparam int c_cnt_w0 = (ACQ_WIDTH > c_clr_w) ? ACQ_WIDTH : c_clr_w;
  localparam int c_cnt_w  = (c_cnt_w0 > c_tmo_w) ? c_cnt_w0 : c_tmo_w;

  localparam logic [c_cnt_w-1:0] c_clr_last = c_cnt_w'(CLEAR_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(READ_TIMEOUT - 1);
  localparam logic [c_bin_w-1:0] c_bin_last = c_bin_w'(BIN_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CONFIG   = 3'd1,
    S_CLEAR    = 3'd2,
    S_ACQUIRE  = 3'd3,
    S_READ_REQ = 3'd4,
    S_READ     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [c_cnt_w-1:0]         r_cnt;
  logic [c_bin_w-1:0]         r_bin;
  logic [CHANNEL_WIDTH-1:0]   r_click_ch;
  logic [CHANNEL_WIDTH-1:0]   r_start_ch;
  logic [SHIFT_WIDTH-1:0]     r_shift;
  logic [ACQ_WIDTH-1:0]       r_acq_last;
  logic [15:0]                r_num_runs;
  logic [15:0]                r_run_count;
  logic                       r_abort_pend;
  logic                       r_error;
  logic [DATA_WIDTH-1:0]      r_m_data;
  logic [c_bin_w-1:0]         r_m_bin;
  logic                       r_m_last;
  logic                       r_m_valid;

  logic                       w_start_ok;
  logic                       w_read_beat;
  logic                       w_last_beat;
  logic                       w_timeout;
  logic                       w_more_runs;
  logic [15:0]                w_rc_inc;

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = (r_state == S_IDLE) && start_i && !abort_i;
    w_read_beat = (r_state == S_READ) && hist_valid_i;
    w_last_beat = w_read_beat && (r_bin == c_bin_last);
    w_timeout   = (r_state == S_READ) && !w_last_beat && (r_cnt == c_tmo_last);
    w_rc_inc    = (r_run_count == 16'hFFFF) ? r_run_count : r_run_count + 16'd1;
    w_more_runs = (r_num_runs == 16'd0) || (w_rc_inc < r_num_runs);

    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_CONFIG;
      end
      S_CONFIG: begin
        w_state_nxt = abort_i ? S_IDLE : S_CLEAR;
      end
      S_CLEAR: begin
        if (abort_i)                  w_state_nxt = S_IDLE;
        else if (r_cnt == c_clr_last) w_state_nxt = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (abort_i)                              w_state_nxt = S_IDLE;
        else if (r_cnt == c_cnt_w'(r_acq_last))   w_state_nxt = S_READ_REQ;
      end
      S_READ_REQ: begin
        // An abort here is only recorded; the readout already requested must drain.
        w_state_nxt = S_READ;
      end
      S_READ: begin
        if (w_last_beat) begin
          if (r_abort_pend || abort_i) w_state_nxt = S_IDLE;
          else if (w_more_runs)        w_state_nxt = S_CLEAR;
          else                         w_state_nxt = S_DONE;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bin        <= '0;
      r_click_ch   <= '0;
      r_start_ch   <= '0;
      r_shift      <= '0;
      r_acq_last   <= '0;
      r_num_runs   <= '0;
      r_run_count  <= '0;
      r_abort_pend <= 1'b0;
      r_error      <= 1'b0;
      r_m_data     <= '0;
      r_m_bin      <= '0;
      r_m_last     <= 1'b0;
      r_m_valid    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // Counter restarts on every state change and measures time-in-state.
      if (r_state == S_IDLE || w_state_nxt != r_state) r_cnt <= '0;
      else                                              r_cnt <= r_cnt + 1'b1;

      if (w_start_ok) begin
        r_click_ch  <= cfg_click_channel_i;
        r_start_ch  <= cfg_start_channel_i;
        r_shift     <= cfg_shift_val_i;
        r_acq_last  <= (cfg_acq_cycles_i == '0) ? '0 : cfg_acq_cycles_i - 1'b1;
        r_num_runs  <= cfg_num_runs_i;
        r_run_count <= '0;
        r_error     <= 1'b0;
      end

      if (r_state == S_IDLE)
        r_abort_pend <= 1'b0;
      else if ((r_state == S_READ_REQ || r_state == S_READ) && abort_i)
        r_abort_pend <= 1'b1;

      if (r_state == S_READ_REQ) r_bin <= '0;
      else if (w_read_beat)      r_bin <= r_bin + 1'b1;

      r_m_valid <= w_read_beat;
      r_m_last  <= w_last_beat;
      if (w_read_beat) begin
        r_m_data <= hist_data_i;
        r_m_bin  <= r_bin;
      end

      if (w_last_beat) r_run_count <= w_rc_inc;

      // Stray beats outside readout take precedence over the start-time clear.
      if (w_timeout || (hist_valid_i && r_state != S_READ)) r_error <= 1'b1;
    end
  end

  assign hist_config_en_o     = (r_state == S_CONFIG);
  assign hist_reset_o         = (r_state == S_CLEAR) && (r_cnt == '0);
  assign hist_read_start_o    = (r_state == S_READ_REQ);
  assign hist_click_channel_o = r_click_ch;
  assign hist_start_channel_o = r_start_ch;
  assign hist_shift_val_o     = r_shift;
  assign m_data_o             = r_m_data;
  assign m_bin_o              = r_m_bin;
  assign m_last_o             = r_m_last;
  assign m_valid_o            = r_m_valid;
  assign busy_o               = (r_state != S_IDLE);
  assign done_o               = (r_state == S_DONE);
  assign run_count_o          = r_run_count;
  assign error_o              = r_error;

endmodule
`default_nettype wire

// File: tb/tb_hist_acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hist_acq_sequencer
// Brief    : Scoreboard bench for hist_acq_sequencer with a histogram model.
// Revision : 1.0
// ============================================================================
module tb_hist_acq_sequencer;

  localparam int CW = 6;
  localparam int SW = 6;
  localparam int DW = 32;
  localparam int BC = 8;
  localparam int CC = 4;
  localparam int AW = 32;
  localparam int RT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, abort_i;
  logic [CW-1:0] cfg_click, cfg_startc;
  logic [SW-1:0] cfg_shift;
  logic [AW-1:0] cfg_acq;
  logic [15:0]   cfg_runs;
  logic          hist_config_en, hist_reset, hist_read_start;
  logic [CW-1:0] hist_click, hist_startc;
  logic [SW-1:0] hist_shift;
  logic [DW-1:0] hist_data;
  logic          hist_valid;
  logic [DW-1:0] m_data;
  logic [2:0]    m_bin;
  logic          m_last, m_valid, busy, done, error;
  logic [15:0]   run_count;

  logic          mdl_valid, stray_valid;
  logic [DW-1:0] mdl_data, stray_data;
  assign hist_valid = mdl_valid | stray_valid;
  assign hist_data  = stray_valid ? stray_data : mdl_data;

  hist_acq_sequencer #(
    .CHANNEL_WIDTH(CW), .SHIFT_WIDTH(SW), .DATA_WIDTH(DW), .BIN_COUNT(BC),
    .CLEAR_CYCLES(CC), .ACQ_WIDTH(AW), .READ_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .cfg_click_channel_i(cfg_click), .cfg_start_channel_i(cfg_startc),
    .cfg_shift_val_i(cfg_shift), .cfg_acq_cycles_i(cfg_acq), .cfg_num_runs_i(cfg_runs),
    .hist_config_en_o(hist_config_en), .hist_click_channel_o(hist_click),
    .hist_start_channel_o(hist_startc), .hist_shift_val_o(hist_shift),
    .hist_reset_o(hist_reset), .hist_read_start_o(hist_read_start),
    .hist_data_i(hist_data), .hist_valid_i(hist_valid),
    .m_data_o(m_data), .m_bin_o(m_bin), .m_last_o(m_last), .m_valid_o(m_valid),
    .busy_o(busy), .done_o(done), .run_count_o(run_count), .error_o(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic [2:0]    bin;
    logic          last;
    logic [15:0]   rc;
  } beat_t;
  beat_t sb[$];

  // Histogram model: answers each read request with nbeats back-to-back bins.
  int nbeats = BC;
  int model_run = 0;
  initial begin
    mdl_valid = 1'b0;
    mdl_data  = '0;
    forever begin
      @(negedge clk);
      if (hist_config_en) model_run = 0;
      if (hist_read_start) begin
        for (int i = 0; i < nbeats; i++) begin
          beat_t b;
          @(negedge clk);
          mdl_valid = 1'b1;
          mdl_data  = 32'hC0DE_0000 | (model_run << 8) | i;
          b.data = mdl_data;
          b.bin  = 3'(i);
          b.last = (i == BC - 1);
          b.rc   = 16'(model_run + 1);
          sb.push_back(b);
        end
        @(negedge clk);
        mdl_valid = 1'b0;
        model_run++;
      end
    end
  end

  int cnt_cfg = 0, cnt_rst = 0, cnt_rd = 0, cnt_done = 0, cnt_beats = 0;
  int cyc_cfg = 0, cyc_rst = 0, cyc_rd = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (hist_config_en)  begin cnt_cfg++; cyc_cfg = cyc; end
      if (hist_reset)      begin cnt_rst++; cyc_rst = cyc; end
      if (hist_read_start) begin cnt_rd++;  cyc_rd  = cyc; end
      if (done) cnt_done++;
      if (m_valid) begin
        cnt_beats++;
        if (sb.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_bin", m_bin, e.bin);
          check("beat_last", m_last, e.last);
          if (e.last) check("run_count_at_last", run_count, e.rc);
        end
      end
    end
  end

  int b_cfg, b_rst, b_rd, b_done, b_beats;
  task automatic snap();
    b_cfg = cnt_cfg; b_rst = cnt_rst; b_rd = cnt_rd; b_done = cnt_done; b_beats = cnt_beats;
  endtask

  task automatic deltas(input string nm, input int ecfg, input int erst, input int erd,
                        input int edone, input int ebeats);
    check({nm, "_cfg_pulses"},  cnt_cfg - b_cfg, ecfg);
    check({nm, "_rst_pulses"},  cnt_rst - b_rst, erst);
    check({nm, "_rd_pulses"},   cnt_rd - b_rd, erd);
    check({nm, "_done_pulses"}, cnt_done - b_done, edone);
    check({nm, "_beats"},       cnt_beats - b_beats, ebeats);
  endtask

  task automatic do_start(input logic [AW-1:0] acq, input logic [15:0] runs);
    @(negedge clk);
    start_i  = 1'b1;
    cfg_acq  = acq;
    cfg_runs = runs;
    @(negedge clk);
    start_i  = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({nm, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    check({nm, "_idle_seen"}, seen, 1'b1);
  endtask

  task automatic wait_reset_pulse(input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (hist_reset) seen = 1'b1;
    end
    check("reset_pulse_seen", seen, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    cfg_click = 6'd5; cfg_startc = 6'd9; cfg_shift = 6'd3;
    cfg_acq = '0; cfg_runs = '0;
    stray_valid = 1'b0; stray_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_run_count", run_count, 16'd0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_click_ch", hist_click, 6'd0);
    check("rst_pulses", {hist_config_en, hist_reset, hist_read_start}, 3'b000);
    rst = 1'b0;

    // Single run, acq = 10.
    snap();
    do_start(32'd10, 16'd1);
    check("t1_config_en", hist_config_en, 1'b1);
    check("t1_click_ch", hist_click, 6'd5);
    check("t1_start_ch", hist_startc, 6'd9);
    check("t1_shift", hist_shift, 6'd3);
    wait_done("t1", 200);
    @(negedge clk);
    check("t1_busy_after", busy, 1'b0);
    check("t1_run_count", run_count, 16'd1);
    check("t1_cfg_to_rst", cyc_rst - cyc_cfg, 1);
    check("t1_rst_to_rd", cyc_rd - cyc_rst, CC + 10);
    deltas("t1", 1, 1, 1, 1, 8);

    // Three runs.
    snap();
    do_start(32'd10, 16'd3);
    wait_done("t3", 400);
    @(negedge clk);
    check("t3_run_count", run_count, 16'd3);
    check("t3_busy_after", busy, 1'b0);
    deltas("t3", 1, 3, 3, 1, 24);

    // Continuous, abort in the middle of run 2's acquisition.
    snap();
    do_start(32'd10, 16'd0);
    wait_reset_pulse(100);
    wait_reset_pulse(100);
    repeat (6) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abacq_busy_next", busy, 1'b0);
    repeat (30) @(negedge clk);
    check("abacq_run_count", run_count, 16'd1);
    deltas("abacq", 1, 2, 1, 0, 8);

    // Abort while bin 3 is on the output stream.
    snap();
    do_start(32'd10, 16'd2);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (m_valid && m_bin == 3'd3) seen = 1'b1;
      end
      check("abrd_bin3_seen", seen, 1'b1);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    wait_idle("abrd", 50);
    repeat (5) @(negedge clk);
    check("abrd_run_count", run_count, 16'd1);
    check("abrd_error", error, 1'b0);
    deltas("abrd", 1, 1, 1, 0, 8);

    // Readout stalls after 5 bins.
    snap();
    nbeats = 5;
    do_start(32'd10, 16'd1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge clk);
        if (error) seen = 1'b1;
      end
      check("tmo_error_seen", seen, 1'b1);
    end
    check("tmo_rd_to_err", cyc - cyc_rd, RT + 1);
    check("tmo_busy", busy, 1'b0);
    deltas("tmo", 1, 1, 1, 0, 5);
    nbeats = BC;
    do_start(32'd10, 16'd1);
    check("tmo_error_cleared", error, 1'b0);
    wait_done("tmo_restart", 200);

    // acq = 0 with a stray histogram beat during the single acquire cycle.
    snap();
    do_start(32'd0, 16'd1);
    wait_reset_pulse(50);
    repeat (4) @(negedge clk);
    stray_valid = 1'b1;
    stray_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    stray_valid = 1'b0;
    check("stray_error", error, 1'b1);
    check("stray_rd_now", hist_read_start, 1'b1);
    wait_done("stray", 200);
    check("stray_rst_to_rd", cyc_rd - cyc_rst, CC + 1);
    check("stray_error_sticky", error, 1'b1);
    deltas("stray", 1, 1, 1, 1, 8);

    // Reset in the middle of an acquisition.
    do_start(32'd50, 16'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_click_ch", hist_click, 6'd0);
    check("midrst_error", error, 1'b0);
    check("midrst_pulses", {hist_config_en, hist_reset, hist_read_start, done}, 4'b0000);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
